// File: rtl/lcd_pkg.sv
// Shared LCD definitions: loader FSM states, 480x272 panel geometry
// and default bus widths for the video memory path.
package lcd_pkg;

    // Loader FSM state encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2,
        FIN   = 2'd3
    } ldr_state_e;

    localparam logic [1:0] ST_IDLE  = 2'(IDLE);
    localparam logic [1:0] ST_FETCH = 2'(FETCH);
    localparam logic [1:0] ST_WRITE = 2'(WRITE);
    localparam logic [1:0] ST_FIN   = 2'(FIN);

    // Panel geometry in pixel clocks / lines.
    localparam int H_ACTIVE = 480;
    localparam int H_FP     = 2;
    localparam int H_SYNC   = 41;
    localparam int H_BP     = 2;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 272;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 10;
    localparam int V_BP     = 2;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Default widths of the image ROM / video RAM path.
    localparam int DATA_W_DEF      = 8;
    localparam int VRAM_ADDR_W_DEF = 11;
    localparam int ROM_ADDR_W_DEF  = 12;

endpackage

// File: rtl/vram_loader.sv
// Copies WORDS words from the image ROM into video RAM during blanking.
// Ports: clk/reset; start+src_base request; den blanking input;
//        rom_addr/rom_data ROM port; vram_addr/vram_wdata/vram_wre RAM
//        write port; busy, done pulse and sticky frame_ready status.
module vram_loader
    import lcd_pkg::*;
#(
    parameter int ROM_ADDR_W  = ROM_ADDR_W_DEF,
    parameter int VRAM_ADDR_W = VRAM_ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int WORDS       = 2048
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ROM_ADDR_W-1:0]  src_base,
    input  logic                   den,
    output logic [ROM_ADDR_W-1:0]  rom_addr,
    input  logic [DATA_W-1:0]      rom_data,
    output logic [VRAM_ADDR_W-1:0] vram_addr,
    output logic [DATA_W-1:0]      vram_wdata,
    output logic                   vram_wre,
    output logic                   busy,
    output logic                   done,
    output logic                   frame_ready
);

    // One extra bit so a full 2**VRAM_ADDR_W copy can be counted.
    localparam int PTR_W = VRAM_ADDR_W + 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(WORDS - 1);

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [PTR_W-1:0]      ptr;
    logic [PTR_W-1:0]      ptr_nxt;
    logic [ROM_ADDR_W-1:0] base;
    logic [ROM_ADDR_W-1:0] ptr_ext;
    logic                  accept;
    logic                  step;
    logic                  last;

    assign accept = (state == ST_IDLE) && start;
    assign step   = (state == ST_WRITE) && !den;
    assign last   = (ptr == LAST);

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_FETCH;
                    ptr_nxt   = '0;
                end
            end
            ST_FETCH: begin
                state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                if (!den) begin
                    if (last) begin
                        state_nxt = ST_FIN;
                    end else begin
                        ptr_nxt = ptr + PTR_W'(1);
                    end
                end
            end
            ST_FIN: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            base        <= '0;
            frame_ready <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            if (accept) begin
                base        <= src_base;
                frame_ready <= 1'b0;
            end else if (state == ST_FIN) begin
                frame_ready <= 1'b1;
            end
        end
    end

    // ROM address runs one word ahead while writing so the next word
    // arrives in time; during a den stall it re-reads the current word
    // so the ROM output stays valid. Wraps modulo the ROM size.
    assign ptr_ext  = ROM_ADDR_W'(ptr);
    assign rom_addr = base + ptr_ext + (step ? ROM_ADDR_W'(1)
                                             : ROM_ADDR_W'(0));

    assign vram_addr  = ptr[VRAM_ADDR_W-1:0];
    assign vram_wdata = rom_data;
    assign vram_wre   = step;

    assign busy = (state == ST_FETCH) || (state == ST_WRITE);
    assign done = (state == ST_FIN);

endmodule
